// File: rtl/cdb_arbiter_pkg.sv
// Shared common-data-bus definitions used by the ROB, the reservation stations and the CDB arbiter.
package cdb_arbiter_pkg;

    localparam int XLEN          = 32;
    localparam int PKG_WAYS      = 3;
    localparam int ROB_SIZE      = 32;
    localparam int PRF_SIZE      = 64;
    localparam int PKG_ROB_IDX_W = $clog2(ROB_SIZE);
    localparam int PKG_PRN_W     = $clog2(PRF_SIZE);

    typedef struct packed {
        logic [PKG_ROB_IDX_W-1:0] rob_idx;
        logic [PKG_PRN_W-1:0]     dest_PRN;
        logic [XLEN-1:0]          value;
        logic                     direction;
        logic [XLEN-1:0]          target;
    } cdb_pkt_t;

    // Round-robin pointer step; the requester count need not be a power of two.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_rr_picker.sv
// Finds the first requester at or after a start pointer, scanning with wrap at N.
module cdb_rr_picker #(
    parameter int N     = 6,
    parameter int PTR_W = 3
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_pick,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_found
);

    always_comb begin
        o_pick  = '0;
        o_idx   = '0;
        o_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            int               w_idx;
            logic [PTR_W-1:0] w_sel;
            w_idx = int'(i_ptr) + k;
            if (w_idx >= N) w_idx = w_idx - N;
            w_sel = PTR_W'(w_idx);
            if (!o_found && i_req[w_sel]) begin
                o_found       = 1'b1;
                o_pick[w_sel] = 1'b1;
                o_idx         = w_sel;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Grants up to WAYS functional-unit completions per cycle in round-robin order
// and registers the winners onto the common data bus lanes.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int WAYS      = PKG_WAYS,
    parameter int NUM_FU    = 6,
    parameter int ROB_IDX_W = PKG_ROB_IDX_W,
    parameter int PRN_W     = PKG_PRN_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       squash,
    input  logic [NUM_FU-1:0]          fu_valid,
    input  logic [ROB_IDX_W-1:0]       fu_rob_idx   [NUM_FU],
    input  logic [PRN_W-1:0]           fu_dest_PRN  [NUM_FU],
    input  logic [XLEN-1:0]            fu_value     [NUM_FU],
    input  logic [NUM_FU-1:0]          fu_direction,
    input  logic [XLEN-1:0]            fu_target    [NUM_FU],
    output logic [NUM_FU-1:0]          fu_grant,
    output logic [WAYS-1:0]            CDB_valid,
    output logic [ROB_IDX_W-1:0]       CDB_ROB_idx   [WAYS],
    output logic [PRN_W-1:0]           CDB_dest_PRN  [WAYS],
    output logic [XLEN-1:0]            CDB_value     [WAYS],
    output logic [WAYS-1:0]            CDB_direction,
    output logic [XLEN-1:0]            CDB_target    [WAYS],
    output logic [$clog2(NUM_FU)-1:0]  dbg_rr_ptr
);

    localparam int PTR_W = $clog2(NUM_FU);

    // Handshake: an FU holds fu_valid with a stable payload; the transfer happens
    // at the rising edge where fu_valid & fu_grant are both high.
    logic [PTR_W-1:0]  r_rr_ptr;
    logic [WAYS-1:0]   r_cdb_valid;
    cdb_pkt_t          r_cdb_pkt  [WAYS];

    logic [NUM_FU-1:0] w_req;
    logic [NUM_FU-1:0] w_pick     [WAYS];
    logic [PTR_W-1:0]  w_pick_idx [WAYS];
    logic [WAYS-1:0]   w_found;
    logic [PTR_W-1:0]  w_last_idx;
    logic [PTR_W-1:0]  w_next_ptr;
    cdb_pkt_t          w_lane_pkt [WAYS];

    assign w_req = (reset || squash) ? '0 : fu_valid;

    // Each lane's picker sees the requests left over after all earlier lanes.
    for (genvar w = 0; w < WAYS; w++) begin : g_lane
        logic [NUM_FU-1:0] w_avail;
        if (w == 0) begin : g_first
            assign w_avail = w_req;
        end else begin : g_next
            assign w_avail = g_lane[w-1].w_avail & ~w_pick[w-1];
        end

        cdb_rr_picker #(
            .N     (NUM_FU),
            .PTR_W (PTR_W)
        ) u_picker (
            .i_req   (w_avail),
            .i_ptr   (r_rr_ptr),
            .o_pick  (w_pick[w]),
            .o_idx   (w_pick_idx[w]),
            .o_found (w_found[w])
        );

        assign CDB_ROB_idx[w]   = r_cdb_pkt[w].rob_idx;
        assign CDB_dest_PRN[w]  = r_cdb_pkt[w].dest_PRN;
        assign CDB_value[w]     = r_cdb_pkt[w].value;
        assign CDB_direction[w] = r_cdb_pkt[w].direction;
        assign CDB_target[w]    = r_cdb_pkt[w].target;
    end

    always_comb begin
        fu_grant = '0;
        for (int w = 0; w < WAYS; w++) begin
            fu_grant = fu_grant | w_pick[w];
        end
    end

    always_comb begin
        w_last_idx = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_found[w]) w_last_idx = w_pick_idx[w];
        end
        w_next_ptr = PTR_W'(wrap_inc(int'(w_last_idx), NUM_FU));
    end

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            w_lane_pkt[w] = '0;
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_pick[w][i]) begin
                    w_lane_pkt[w].rob_idx   = fu_rob_idx[i];
                    w_lane_pkt[w].dest_PRN  = fu_dest_PRN[i];
                    w_lane_pkt[w].value     = fu_value[i];
                    w_lane_pkt[w].direction = fu_direction[i];
                    w_lane_pkt[w].target    = fu_target[i];
                end
            end
        end
    end

    // Squash needs no branch here: it already suppresses every pick.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr    <= '0;
            r_cdb_valid <= '0;
            for (int w = 0; w < WAYS; w++) r_cdb_pkt[w] <= '0;
        end else begin
            if (|w_found) r_rr_ptr <= w_next_ptr;
            r_cdb_valid <= w_found;
            for (int w = 0; w < WAYS; w++) r_cdb_pkt[w] <= w_lane_pkt[w];
        end
    end

    assign CDB_valid  = r_cdb_valid;
    assign dbg_rr_ptr = r_rr_ptr;

endmodule
